mem_arbiter: RTL and testbench

// - Sits directly downstream of cpu_core: consumes its 2 read ports (0 = IF fetch, 1 = MA load)
//   and 1 write port (0 = MA store), serialises them onto one byte-wide synchronous RAM.
// - Assembles/splits 1/2/4-byte accesses little-endian; one transaction in flight at a time.

---
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Serialises cpu_core read/write ports onto one byte-wide synchronous RAM, little-endian.
// Define MEM_ARB_RR_EN for round-robin arbitration between the two read ports.
module mem_arbiter #(
   parameter int ADDR_W = 17,
   parameter int R_PORT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [32*R_PORT-1:0]  co_raddr,
   input  logic [R_PORT-1:0]     co_re,
   input  logic [2*R_PORT-1:0]   co_rlen,
   output logic [32*R_PORT-1:0]  co_din,
   output logic [R_PORT-1:0]     co_rack,
   input  logic [31:0]           co_waddr,
   input  logic [31:0]           co_dout,
   input  logic                  co_we,
   input  logic [1:0]            co_wlen,
   output logic                  co_wack,
   output logic [ADDR_W-1:0]     mem_a,
   output logic [7:0]            mem_dout,
   input  logic [7:0]            mem_din,
   output logic                  mem_wr
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [1:0]            last_q, last_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  port_q, port_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [2:0]            cool_q, cool_d;
   logic [32*R_PORT-1:0]  din_q, din_d;
   logic [R_PORT-1:0]     rack_q, rack_d;
   logic                  wack_q, wack_d;
   logic [ADDR_W-1:0]     mem_a_q, mem_a_d;
   logic [7:0]            mem_dout_q, mem_dout_d;
   logic                  mem_wr_q, mem_wr_d;
`ifdef MEM_ARB_RR_EN
   logic                  rr_q, rr_d;
`endif

   logic                  req_w, req1, req0, gport;
   logic [ADDR_W-1:0]     raddr_g, addr_nx;
   logic [1:0]            rlen_g, byte_sel;
   logic [2:0]            cnt_nx, last_ext;
   logic                  unused_addr_bits;

   function automatic logic [1:0] len_last(input logic [1:0] len);
      case (len)
         2'b00:   len_last = 2'd0;
         2'b01:   len_last = 2'd1;
         default: len_last = 2'd3;
      endcase
   endfunction

   always_comb begin
      unused_addr_bits = ^{co_waddr[31:ADDR_W], co_raddr[63:32+ADDR_W], co_raddr[31:ADDR_W]};
   end

   always_comb begin
      // Cooldown masks the requester acked last cycle so a late-dropping requester is not re-served.
      req_w = co_we    & ~cool_q[2];
      req1  = co_re[1] & ~cool_q[1];
      req0  = co_re[0] & ~cool_q[0];
`ifdef MEM_ARB_RR_EN
      gport = (req1 && req0) ? ~rr_q : req1;
`else
      gport = req1;
`endif
      raddr_g  = co_raddr[{gport, 5'b00000} +: ADDR_W];
      rlen_g   = co_rlen[{gport, 1'b0} +: 2];
      cnt_nx   = cnt_q + 3'd1;
      last_ext = {1'b0, last_q};
      addr_nx  = base_q + {{(ADDR_W-3){1'b0}}, cnt_nx};
      byte_sel = cnt_q[1:0] - 2'd1;
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      last_d     = last_q;
      wdata_d    = wdata_q;
      port_d     = port_q;
      cnt_d      = cnt_q;
      cool_d     = '0;
      din_d      = din_q;
      rack_d     = '0;
      wack_d     = 1'b0;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_d       = rr_q;
`endif

      case (state_q)
         IDLE: begin
            if (req_w) begin
               state_d    = WRITE;
               base_d     = co_waddr[ADDR_W-1:0];
               last_d     = len_last(co_wlen);
               wdata_d    = co_dout;
               cnt_d      = '0;
               mem_a_d    = co_waddr[ADDR_W-1:0];
               mem_dout_d = co_dout[7:0];
               mem_wr_d   = 1'b1;
            end else if (req1 || req0) begin
               state_d = READ;
               base_d  = raddr_g;
               last_d  = len_last(rlen_g);
               port_d  = gport;
               cnt_d   = '0;
               mem_a_d = raddr_g;
               din_d[{gport, 5'b00000} +: 32] = '0;
`ifdef MEM_ARB_RR_EN
               rr_d    = gport;
`endif
            end
         end

         READ: begin
            // RAM data lags the address by one cycle, so cycle c captures byte c-1.
            cnt_d = cnt_nx;
            if (cnt_q != 3'd0) begin
               din_d[{port_q, byte_sel, 3'b000} +: 8] = mem_din;
            end
            if (cnt_q == last_ext + 3'd1) begin
               state_d        = DONE;
               rack_d[port_q] = 1'b1;
            end else if (cnt_q < last_ext) begin
               mem_a_d = addr_nx;
            end
         end

         WRITE: begin
            if (cnt_q == last_ext) begin
               state_d = DONE;
               wack_d  = 1'b1;
            end else begin
               cnt_d      = cnt_nx;
               mem_a_d    = addr_nx;
               mem_dout_d = wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
               mem_wr_d   = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
            cool_d  = {wack_q, rack_q[1], rack_q[0]};
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         last_q     <= '0;
         wdata_q    <= '0;
         port_q     <= 1'b0;
         cnt_q      <= '0;
         cool_q     <= '0;
         din_q      <= '0;
         rack_q     <= '0;
         wack_q     <= 1'b0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
         rr_q       <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         last_q     <= last_d;
         wdata_q    <= wdata_d;
         port_q     <= port_d;
         cnt_q      <= cnt_d;
         cool_q     <= cool_d;
         din_q      <= din_d;
         rack_q     <= rack_d;
         wack_q     <= wack_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
`ifdef MEM_ARB_RR_EN
         rr_q       <= rr_d;
`endif
      end
   end

   assign co_din   = din_q;
   assign co_rack  = rack_q;
   assign co_wack  = wack_q;
   assign mem_a    = mem_a_q;
   assign mem_dout = mem_dout_q;
   assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected acks/RAM writes, a monitor checks them.
module tb_mem_arbiter;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [63:0]   co_raddr;
   logic [1:0]    co_re;
   logic [3:0]    co_rlen;
   logic [63:0]   co_din;
   logic [1:0]    co_rack;
   logic [31:0]   co_waddr;
   logic [31:0]   co_dout;
   logic          co_we;
   logic [1:0]    co_wlen;
   logic          co_wack;
   logic [AW-1:0] mem_a;
   logic [7:0]    mem_dout;
   logic [7:0]    mem_din = '0;
   logic          mem_wr;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .R_PORT(2)) dut (
      .clk(clk), .rst(rst),
      .co_raddr(co_raddr), .co_re(co_re), .co_rlen(co_rlen), .co_din(co_din), .co_rack(co_rack),
      .co_waddr(co_waddr), .co_dout(co_dout), .co_we(co_we), .co_wlen(co_wlen), .co_wack(co_wack),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din), .mem_wr(mem_wr)
   );

   // Byte-wide synchronous RAM with a side port for preloading.
   logic [7:0]    ram [0:(1<<AW)-1];
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_a = '0;
   logic [7:0]    poke_d = '0;
   always @(posedge clk) begin
      if (mem_wr) ram[mem_a] <= mem_dout;
      else if (poke_en) ram[poke_a] <= poke_d;
      mem_din <= ram[mem_a];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int kind; logic [31:0] data; int cyc; } ack_t;
   typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
   ack_t        ack_q[$];
   wr_t         wr_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [63:0] din_m = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic handle_ack(input int kind);
      ack_t e;
      if (ack_q.size() == 0) begin
         chk("ack_unexpected", 64'(ack_q.size()), 64'd1);
         return;
      end
      e = ack_q.pop_front();
      chk("ack_kind", 64'(kind), 64'(e.kind));
      chk("ack_cycle", 64'(cyc), 64'(e.cyc));
      if (kind != 2) begin
         din_m[32*kind +: 32] = e.data;
         chk("co_din", co_din, din_m);
      end
   endtask

   // Monitor: consumes expectations whenever the DUT acks or writes RAM.
   initial forever begin
      wr_t w;
      @(negedge clk);
      if (rst) begin
         din_m = '0;
      end else begin
         if (mem_wr) begin
            if (wr_q.size() == 0) begin
               chk("mem_wr_unexpected", 64'(wr_q.size()), 64'd1);
            end else begin
               w = wr_q.pop_front();
               chk("mem_a", 64'(mem_a), 64'(w.a));
               chk("mem_dout", 64'(mem_dout), 64'(w.d));
            end
         end
         if (co_wack)    handle_ack(2);
         if (co_rack[1]) handle_ack(1);
         if (co_rack[0]) handle_ack(0);
      end
   end

   task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
      poke_en = 1'b1; poke_a = a; poke_d = d;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic issue_read(input int p, input logic [31:0] addr, input logic [1:0] len);
      co_raddr[32*p +: 32] = addr;
      co_rlen[2*p +: 2]    = len;
      co_re[p]             = 1'b1;
   endtask

   task automatic issue_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] len);
      co_waddr = addr; co_dout = data; co_wlen = len; co_we = 1'b1;
   endtask

   task automatic exp_ack(input int kind, input logic [31:0] data, input int c);
      ack_q.push_back('{kind: kind, data: data, cyc: c});
   endtask

   task automatic exp_byte(input logic [AW-1:0] a, input logic [7:0] d);
      wr_q.push_back('{a: a, d: d});
   endtask

   // Drop each request when acked (port 0 optionally one cycle late); bounded wait.
   task automatic drain(input bit hold0);
      int budget = 60;
      bit late = 1'b0;
      while ((co_we || co_re != 2'b00 || late) && budget > 0) begin
         @(negedge clk);
         budget--;
         if (late) begin co_re[0] = 1'b0; late = 1'b0; end
         if (co_wack) co_we = 1'b0;
         if (co_rack[1]) co_re[1] = 1'b0;
         if (co_rack[0]) begin
            if (hold0) late = 1'b1;
            else co_re[0] = 1'b0;
         end
      end
      chk("requests_drained", 64'({co_we, co_re}), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int k;
      co_raddr = '0; co_re = '0; co_rlen = '0;
      co_waddr = '0; co_dout = '0; co_we = 1'b0; co_wlen = '0;
      repeat (3) @(negedge clk);
      chk("rst_co_din", co_din, 64'd0);
      chk("rst_acks", 64'({co_rack, co_wack}), 64'd0);
      chk("rst_mem", 64'({mem_a, mem_dout, mem_wr}), 64'd0);
      rst = 1'b0;

      poke(17'h10, 8'h11); poke(17'h11, 8'h22); poke(17'h12, 8'h33); poke(17'h13, 8'h44);
      poke(17'h14, 8'h55);
      poke(17'h24, 8'hFF); poke(17'h25, 8'hFF); poke(17'h26, 8'hFF); poke(17'h27, 8'hFF);
      poke(17'h20, 8'h80);
      poke(17'h30, 8'h01); poke(17'h31, 8'h02); poke(17'h32, 8'h03); poke(17'h33, 8'h04);
      @(negedge clk);

      // Word read, port 0
      issue_read(0, 32'h10, 2'b10); exp_ack(0, 32'h44332211, cyc + 6); drain(1'b0);

      // Half write wrapping past the top of the address space, then read it back
      issue_write(32'h0001FFFF, 32'h0000BEEF, 2'b01);
      exp_byte(17'h1FFFF, 8'hEF); exp_byte(17'h00000, 8'hBE); exp_ack(2, 32'h0, cyc + 3);
      drain(1'b0);
      issue_read(0, 32'h0001FFFF, 2'b01); exp_ack(0, 32'h0000BEEF, cyc + 4); drain(1'b0);

      // Port 1 slice set to all-ones, then a byte read must clear upper bytes
      issue_read(1, 32'h24, 2'b10); exp_ack(1, 32'hFFFFFFFF, cyc + 6); drain(1'b0);
      issue_read(1, 32'h20, 2'b00); exp_ack(1, 32'h00000080, cyc + 3); drain(1'b0);

      // Write and both reads together: write first, read of same address sees new byte
      k = cyc;
      issue_write(32'h30, 32'h123456A5, 2'b00);
      issue_read(1, 32'h30, 2'b10);
      issue_read(0, 32'h10, 2'b10);
      exp_byte(17'h30, 8'hA5);
      exp_ack(2, 32'h0, k + 2);
      exp_ack(1, 32'h040302A5, k + 9);
      exp_ack(0, 32'h44332211, k + 16);
      drain(1'b0);

      // Unaligned word read with len 11
      issue_read(1, 32'h11, 2'b11); exp_ack(1, 32'h55443322, cyc + 6); drain(1'b0);

      // Async reset in the middle of a word read
      issue_read(0, 32'h10, 2'b10);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_co_din", co_din, 64'd0);
      chk("midrst_acks", 64'({co_rack, co_wack}), 64'd0);
      chk("midrst_mem", 64'({mem_a, mem_dout, mem_wr}), 64'd0);
      co_re = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      issue_read(0, 32'h30, 2'b10); exp_ack(0, 32'h040302A5, cyc + 6); drain(1'b0);

      // Requester holds one cycle past ack: cooldown prevents a second grant
      issue_read(0, 32'h12, 2'b00); exp_ack(0, 32'h00000033, cyc + 3); drain(1'b1);
      repeat (6) @(negedge clk);

      // Both reads together: port 1 first, then port 0
      k = cyc;
      issue_read(1, 32'h20, 2'b00);
      issue_read(0, 32'h13, 2'b00);
      exp_ack(1, 32'h00000080, k + 3);
      exp_ack(0, 32'h00000044, k + 7);
      drain(1'b0);
      repeat (4) @(negedge clk);

      chk("ack_queue_empty", 64'(ack_q.size()), 64'd0);
      chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
